// File: rtl/wb_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter_if                                                   |
// | Requester and register-file write-back signals for wb_port_arbiter.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface wb_port_arbiter_if;
   logic        a_valid;
   logic [3:0]  a_dest;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [3:0]  b_dest;
   logic [31:0] b_data;
   logic        b_ready;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic        b_forced;

   // Arbiter side: takes requests, drives readies and the register-file port
   modport slave (
      input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
      output a_ready, b_ready, wb_en, wb_dest, wb_data, b_forced
   );

   modport master (
      output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
      input  a_ready, b_ready, wb_en, wb_dest, wb_data, b_forced
   );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter                                                      |
// | Shares one register-file write port: A has priority, B is forced    |
// | through after MAX_WAIT blocked cycles. Writes appear one cycle late. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   wb_port_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      A_PRI   = 1'b0,
      B_FORCE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] c_MAX_M1 = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_wb_en;
   logic [3:0]        r_wb_dest;
   logic [31:0]       r_wb_data;

   logic w_a_ready;
   logic w_b_ready;
   logic w_a_xfer;
   logic w_b_xfer;
   logic w_b_blocked;

   assign w_a_ready   = !rst && (r_state == A_PRI);
   assign w_b_ready   = !rst && ((r_state == B_FORCE) || !bus.a_valid);
   assign w_a_xfer    = bus.a_valid && w_a_ready;
   assign w_b_xfer    = bus.b_valid && w_b_ready;
   assign w_b_blocked = bus.b_valid && !w_b_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= A_PRI;
         r_wait_cnt <= '0;
         r_wb_en    <= 1'b0;
         r_wb_dest  <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_en <= w_a_xfer || w_b_xfer;
         if (w_a_xfer) begin
            r_wb_dest <= bus.a_dest;
            r_wb_data <= bus.a_data;
         end else if (w_b_xfer) begin
            r_wb_dest <= bus.b_dest;
            r_wb_data <= bus.b_data;
         end

         case (r_state)
            A_PRI: begin
               // Not blocked means B either transferred or is idle: both clear the count
               if (w_b_blocked) begin
                  if (r_wait_cnt == c_MAX_M1) begin
                     r_state <= B_FORCE;
                  end
                  if (r_wait_cnt != c_MAX) begin
                     r_wait_cnt <= r_wait_cnt + c_ONE;
                  end
               end else begin
                  r_wait_cnt <= '0;
               end
            end
            B_FORCE: begin
               // b_ready is unconditional here, so B either transfers or has withdrawn
               r_state    <= A_PRI;
               r_wait_cnt <= '0;
            end
            default: begin
               r_state    <= A_PRI;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.a_ready  = w_a_ready;
   assign bus.b_ready  = w_b_ready;
   // Gating by rst drops a write still being presented when reset arrives
   assign bus.wb_en    = r_wb_en && !rst;
   assign bus.wb_dest  = r_wb_dest;
   assign bus.wb_data  = r_wb_data;
   assign bus.b_forced = (r_state == B_FORCE);

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_wb_port_arbiter                                                   |
// | Directed stimulus with a write-back scoreboard for wb_port_arbiter.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wb_port_arbiter;

   typedef struct {
      int          due;
      logic [3:0]  dest;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];

   wb_port_arbiter_if bus();

   wb_port_arbiter #(
      .MAX_WAIT (4),
      .CNT_W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [3:0] dest, input logic [31:0] data);
      exp_t e;
      e.due  = cyc + 1;
      e.dest = dest;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                        input logic bv, input logic [3:0] bd, input logic [31:0] bdat);
      bus.a_valid = av;
      bus.a_dest  = ad;
      bus.a_data  = adat;
      bus.b_valid = bv;
      bus.b_dest  = bd;
      bus.b_data  = bdat;
   endtask

   // Four cycles of A holding the port while B waits, then B_FORCE in the fifth
   task automatic starve(input logic [3:0] base, input bit push_last);
      logic [3:0] d;
      for (int i = 0; i < 4; i++) begin
         d = base + 4'(i);
         drive(1'b1, d, 32'hA000_0000 + 32'(d), 1'b1, 4'd9, 32'hB0B0_0009);
         #1;
         check("starve_b_ready", 32'(bus.b_ready), 32'd0);
         check("starve_a_ready", 32'(bus.a_ready), 32'd1);
         check("starve_b_forced", 32'(bus.b_forced), 32'd0);
         if (i < 3 || push_last) push(d, 32'hA000_0000 + 32'(d));
         step();
      end
      d = base + 4'd4;
      drive(1'b1, d, 32'hA000_0000 + 32'(d), 1'b1, 4'd9, 32'hB0B0_0009);
      #1;
      check("force_b_forced", 32'(bus.b_forced), 32'd1);
      check("force_a_ready", 32'(bus.a_ready), 32'd0);
      check("force_b_ready", 32'(bus.b_ready), 32'd1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].due < cyc) begin
         e = q.pop_front();
         checks++;
         failures++;
         $display("FAIL wb_missed: expected dest %0d data %0h at cycle %0d", e.dest, e.data, e.due);
      end else if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         checks++;
         if (bus.wb_en !== 1'b1 || bus.wb_dest !== e.dest || bus.wb_data !== e.data) begin
            failures++;
            $display("FAIL wb_write: got en %b dest %0d data %0h expected en 1 dest %0d data %0h",
                     bus.wb_en, bus.wb_dest, bus.wb_data, e.dest, e.data);
         end
      end else begin
         checks++;
         if (bus.wb_en !== 1'b0) begin
            failures++;
            $display("FAIL wb_idle: got en %b dest %0d data %0h expected en 0 (cycle %0d)",
                     bus.wb_en, bus.wb_dest, bus.wb_data, cyc);
         end
      end
   end

   initial begin
      // Reset with both requesters asserting
      drive(1'b1, 4'd1, 32'h1111_1111, 1'b1, 4'd2, 32'h2222_2222);
      step();
      check("rst_a_ready", 32'(bus.a_ready), 32'd0);
      check("rst_b_ready", 32'(bus.b_ready), 32'd0);
      step();
      check("rst_b_forced", 32'(bus.b_forced), 32'd0);

      // A only, first edge after reset release
      rst = 1'b0;
      drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0);
      #1;
      check("a_only_ready", 32'(bus.a_ready), 32'd1);
      push(4'd3, 32'hDEAD_BEEF);
      step();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      step();
      step();

      // B only
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h1234_5678);
      #1;
      check("b_only_ready", 32'(bus.b_ready), 32'd1);
      check("b_only_forced", 32'(bus.b_forced), 32'd0);
      push(4'd7, 32'h1234_5678);
      step();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      #1;
      check("b_only_forced_after", 32'(bus.b_forced), 32'd0);
      step();

      // Starvation: B forced in cycle 5, A resumes in cycle 6
      starve(4'd1, 1'b1);
      push(4'd9, 32'hB0B0_0009);
      step();
      drive(1'b1, 4'd5, 32'hA000_0005, 1'b0, 4'd0, 32'h0);
      #1;
      check("resume_b_forced", 32'(bus.b_forced), 32'd0);
      check("resume_a_ready", 32'(bus.a_ready), 32'd1);
      push(4'd5, 32'hA000_0005);
      step();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      step();

      // Reset right after accepting A dest 5: the write is discarded
      drive(1'b1, 4'd5, 32'h5555_5555, 1'b0, 4'd0, 32'h0);
      step();
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      step();
      rst = 1'b0;
      step();

      // Reset while in B_FORCE; the last A write is still in flight and is dropped
      starve(4'd8, 1'b0);
      rst = 1'b1;
      step();
      check("rst_bforce_b_forced", 32'(bus.b_forced), 32'd0);
      rst = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      #1;
      check("rst_bforce_a_ready", 32'(bus.a_ready), 32'd1);
      step();

      // Withdrawn B in B_FORCE: no write, back to A_PRI with the wait count cleared
      starve(4'd2, 1'b1);
      drive(1'b1, 4'd6, 32'hA000_0006, 1'b0, 4'd0, 32'h0);
      #1;
      check("withdraw_a_ready", 32'(bus.a_ready), 32'd0);
      step();
      check("withdraw_b_forced", 32'(bus.b_forced), 32'd0);
      starve(4'd10, 1'b1);
      push(4'd9, 32'hB0B0_0009);
      step();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      step();
      step();

      check("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write-back port (writeBackEn / Dest_wb / Result_WB) between two requesters:
  - A: the pipeline WB stage, which has priority.
  - B: a multi-cycle unit such as a multiplier or memory, which gets a starvation guarantee.
- Sits between the WB stage / multi-cycle unit and the register file.
- Drives the file's write inputs from a registered output stage, so every write appears one cycle after acceptance.

Parameters:
- MAX_WAIT, 4: number of consecutive cycles B may be blocked before it is forced through. Legal range is 1..15.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_dest  in  4  A destination register index
- a_data  in  32  A write data
- a_ready  out  1  A write accepted this cycle if a_valid
- b_valid  in  1  requester B has a write pending; must be held until accepted
- b_dest  in  4  B destination register index
- b_data  in  32  B write data
- b_ready  out  1  B write accepted this cycle if b_valid
- wb_en  out  1  to register file writeBackEn
- wb_dest  out  4  to register file Dest_wb
- wb_data  out  32  to register file Result_WB
- b_forced  out  1  high while in state B_FORCE (status for the stall logic)

Behaviour:
- Reset (rst high at a posedge):
  - state=A_PRI, wait_cnt=0, wb_en=0, wb_dest=0, wb_data=0.
  - a_ready and b_ready are 0 combinationally while rst is high.
  - A write accepted in the cycle before reset and not yet presented is discarded; no write is issued.
- Transfer rule: a transfer occurs when valid && ready at a posedge. At most one transfer per cycle, so no same-cycle destination conflict exists. Writes reach the file in acceptance order.
- States:
  - A_PRI: a_ready=1; b_ready=!a_valid.
  - B_FORCE: a_ready=0; b_ready=1.
- Output stage (registered, latency 1):
  - On a transfer: wb_en=1, wb_dest/wb_data = the accepted requester's dest/data on the next cycle.
  - With no transfer: wb_en=0 and wb_dest/wb_data hold their previous values.
  - Back-to-back transfers produce wb_en high on consecutive cycles.
- wait_cnt:
  - In A_PRI, increments when b_valid && !b_ready, saturating at MAX_WAIT.
  - Clears on any B transfer or when b_valid=0.
- Transitions:
  - A_PRI -> B_FORCE at a posedge where b_valid && !b_ready && wait_cnt==MAX_WAIT-1. B is therefore blocked at most MAX_WAIT cycles and accepted in cycle MAX_WAIT+1.
  - B_FORCE -> A_PRI after the B transfer; wait_cnt=0.
  - B_FORCE -> A_PRI if b_valid drops (protocol violation); no write is issued.
- b_forced = (state==B_FORCE).
- If A and B target the same register in successive accepted transfers, the later write wins. The arbiter does no merging.
- dest 15 is treated as any other register; PC handling is outside this block.

Test Plan:
- Reset: assert rst with a_valid=b_valid=1 -> a_ready=b_ready=0 and wb_en=0. The first posedge after rst falls accepts A.
- A only: a_valid=1, a_dest=3, a_data=0xDEADBEEF -> the next cycle shows wb_en=1, wb_dest=3, wb_data=0xDEADBEEF. Idle cycles after it show wb_en=0.
- B only: b_valid=1, b_dest=7, b_data=0x12345678, a_valid=0 -> b_ready=1 immediately; the next cycle shows wb_en=1, wb_dest=7. b_forced stays 0.
- Starvation, MAX_WAIT=4:
  - Stimulus: a_valid held 1 (dests 1,2,3,4,...) with b_valid=1, b_dest=9.
  - Required: b_ready=0 for cycles 1-4; cycle 5 shows b_forced=1, a_ready=0, b accepted; cycle 6 shows wb_dest=9.
  - Then: cycle 6 is back in A_PRI with a accepted.
- Reset mid-operation: accept A (dest 5) and assert rst on the next posedge -> no write to register 5 occurs. The same holds when rst is asserted while in B_FORCE: state returns to A_PRI and b_forced=0.
- Withdrawn B: in B_FORCE, drop b_valid -> return to A_PRI with no write issued and wait_cnt=0.
